// File: rtl/mul_seq_w_if.sv
// rtl/mul_seq_w_if.sv - request/response bundle for the sequential multiplier
interface mul_seq_w_if #(
  parameter int W = 32
);
  logic           start;
  logic           sgn;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] res;

  // issue side drives the request, observes completion
  modport master (
    output start, sgn, op1, op2,
    input  busy, done, res
  );

  // multiplier side
  modport slave (
    input  start, sgn, op1, op2,
    output busy, done, res
  );
endinterface

// File: rtl/mul_seq_w.sv
// rtl/mul_seq_w.sv - radix-2 shift-add multiplier, W x W -> 2W, signed/unsigned per op
// Optional feature macro: MUL_SEQ_EARLY_EXIT_EN (finish as soon as the remaining multiplier is zero)
module mul_seq_w #(
  parameter int W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mul_seq_w_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [2*W-1:0]  r_res;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_busy;
  logic            r_done;

  logic [W-1:0]    w_mag1;
  logic [W-1:0]    w_mag2;
  logic [W-1:0]    w_mplier_shr;
  logic            w_last_iter;
  logic            w_run_exit;
  logic            w_skip_run;

  // Magnitudes of the operands; -2^(W-1) negates to itself, which reads correctly as unsigned
  assign w_mag1       = (bus.sgn && bus.op1[W-1]) ? -bus.op1 : bus.op1;
  assign w_mag2       = (bus.sgn && bus.op2[W-1]) ? -bus.op2 : bus.op2;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_last_iter  = (r_cnt == CW'(W - 1));

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign w_run_exit = w_last_iter || (w_mplier_shr == '0);
  assign w_skip_run = (w_mag2 == '0);
`else
  assign w_run_exit = w_last_iter;
  assign w_skip_run = 1'b0;
`endif

  // Control FSM and datapath: accept, iterate shift-add, sign-correct and publish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= {{W{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= bus.sgn & (bus.op1[W-1] ^ bus.op2[W-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= w_skip_run ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + CW'(1);
          if (w_run_exit) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_res   <= r_neg ? -r_acc : r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.res  = r_res;

endmodule
